// File: rtl/serdes_hdr_err_inject.sv
// Sync-header error injector between TX and RX SERDES: LFSR/forced events corrupt bursts of headers.
// Define HDR_ERR_INJECT_DATA_FLIP_EN to also flip one LFSR-selected data bit per corrupted header.
module serdes_hdr_err_inject #(
    parameter int          DATA_WIDTH = 64,
    parameter int          HDR_WIDTH  = 2,
    parameter logic [31:0] LFSR_SEED  = 32'h1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [HDR_WIDTH-1:0]  in_hdr,
    input  logic                  cfg_enable,
    input  logic [31:0]           cfg_threshold,
    input  logic [7:0]            cfg_burst_len,
    input  logic                  cfg_force,
    input  logic                  stat_clear,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [HDR_WIDTH-1:0]  out_hdr,
    output logic                  out_err,
    output logic [31:0]           stat_inj_count,
    output logic [31:0]           stat_evt_count,
    output logic                  busy
);

    localparam logic [31:0]          LFSR_INIT = (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;
    // Right-shift Galois form of x^32 + x^22 + x^2 + x + 1
    localparam logic [31:0]          LFSR_TAPS = 32'h8020_0003;
    localparam logic [HDR_WIDTH-1:0] HDR_FLIP  = HDR_WIDTH'(1);
    localparam logic [31:0]          CNT_MAX   = 32'hFFFF_FFFF;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t                  state_reg;
    logic [7:0]              remaining_reg;
    logic [31:0]             lfsr_reg;
    logic [31:0]             lfsr_next;
    logic                    trigger;
    logic                    corrupt;
    logic                    evt_inc;
    logic [7:0]              eff_len;
    logic [DATA_WIDTH-1:0]   data_next;
    logic [HDR_WIDTH-1:0]    hdr_next;

    assign lfsr_next = {1'b0, lfsr_reg[31:1]} ^ (lfsr_reg[0] ? LFSR_TAPS : 32'h0);
    assign trigger   = cfg_enable && ((lfsr_reg < cfg_threshold) || cfg_force);
    assign eff_len   = (cfg_burst_len == 8'd0) ? 8'd1 : cfg_burst_len;

    // In BURST triggers are ignored; dropping cfg_enable aborts without corrupting.
    always_comb begin
        corrupt = 1'b0;
        evt_inc = 1'b0;
        case (state_reg)
            IDLE: begin
                corrupt = trigger;
                evt_inc = trigger;
            end
            BURST: begin
                corrupt = cfg_enable;
            end
            default: begin
                corrupt = 1'b0;
                evt_inc = 1'b0;
            end
        endcase
    end

    assign hdr_next = corrupt ? (in_hdr ^ HDR_FLIP) : in_hdr;

`ifdef HDR_ERR_INJECT_DATA_FLIP_EN
    logic [DATA_WIDTH-1:0] flip_mask;
    logic [5:0]            flip_sel;

    assign flip_sel = lfsr_reg[5:0];

    generate
        for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_flip
            assign flip_mask[gi] = corrupt && ((int'(flip_sel) % DATA_WIDTH) == gi);
        end
    endgenerate

    assign data_next = in_data ^ flip_mask;
`else
    assign data_next = in_data;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data      <= '0;
            out_hdr       <= '0;
            out_err       <= 1'b0;
            busy          <= 1'b0;
            state_reg     <= IDLE;
            remaining_reg <= 8'd0;
            lfsr_reg      <= LFSR_INIT;
        end else begin
            out_data <= data_next;
            out_hdr  <= hdr_next;
            out_err  <= corrupt;

            if (cfg_enable) begin
                lfsr_reg <= lfsr_next;
            end

            case (state_reg)
                IDLE: begin
                    // Burst length is captured only here, so mid-burst edits are ignored.
                    if (trigger && (eff_len > 8'd1)) begin
                        remaining_reg <= eff_len - 8'd1;
                        state_reg     <= BURST;
                        busy          <= 1'b1;
                    end
                end
                BURST: begin
                    if (!cfg_enable) begin
                        remaining_reg <= 8'd0;
                        state_reg     <= IDLE;
                        busy          <= 1'b0;
                    end else begin
                        remaining_reg <= remaining_reg - 8'd1;
                        if (remaining_reg == 8'd1) begin
                            state_reg <= IDLE;
                            busy      <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    remaining_reg <= 8'd0;
                    busy          <= 1'b0;
                end
            endcase
        end
    end

    // Saturating statistics; a clear beats a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_inj_count <= 32'h0;
            stat_evt_count <= 32'h0;
        end else if (stat_clear) begin
            stat_inj_count <= 32'h0;
            stat_evt_count <= 32'h0;
        end else begin
            if (corrupt && (stat_inj_count != CNT_MAX)) begin
                stat_inj_count <= stat_inj_count + 32'h1;
            end
            if (evt_inc && (stat_evt_count != CNT_MAX)) begin
                stat_evt_count <= stat_evt_count + 32'h1;
            end
        end
    end

endmodule

// File: doc/serdes_hdr_err_inject.md
SERDES_HDR_ERR_INJECT -- requirements
Module: serdes_hdr_err_inject

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64: width of the SERDES data word.
REQ-002 SHALL have parameter HDR_WIDTH, default 2: width of the sync header.
REQ-003 SHALL have parameter LFSR_SEED, default 32'h1: LFSR reset value; a value of 0 SHALL be replaced by 32'h1.
REQ-004 SHALL have ports, one per line (name, direction, width, meaning):
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_data  in  DATA_WIDTH  data word from the TX SERDES side.
- in_hdr  in  HDR_WIDTH  sync header from the TX SERDES side.
- cfg_enable  in  1  injection enable.
- cfg_threshold  in  32  random-injection threshold.
- cfg_burst_len  in  8  headers corrupted per event; 0 is treated as 1.
- cfg_force  in  1  one-cycle pulse that forces an injection event.
- stat_clear  in  1  synchronous clear of both statistics counters.
- out_data  out  DATA_WIDTH  data word to the RX SERDES input.
- out_hdr  out  HDR_WIDTH  sync header to the RX SERDES input.
- out_err  out  1  high in the same cycle that out_hdr is corrupted.
- stat_inj_count  out  32  count of corrupted headers.
- stat_evt_count  out  32  count of injection events.
- busy  out  1  high while in BURST.

Function
REQ-005 SHALL register all outputs, with a fixed latency of 1 cycle from in_* to out_*, and SHALL accept a new word every cycle.
REQ-006 SHALL advance a 32-bit Galois LFSR (x^32+x^22+x^2+x+1) once per cycle when cfg_enable=1, and SHALL hold the LFSR otherwise.
REQ-007 SHALL raise an event trigger when cfg_enable=1 and either the LFSR value (before advancing) is below cfg_threshold, unsigned, or cfg_force=1.
REQ-008 SHALL corrupt a header as out_hdr = in_hdr XOR 2'b01, mapping 10->11 and 01->00, so the result is always invalid.
REQ-009 SHALL implement an FSM with states IDLE and BURST; the reset state is IDLE.
REQ-010 IDLE: on a trigger, SHALL corrupt the current header and increment stat_evt_count. If the effective burst length is greater than 1, it SHALL load remaining = length-1 and go to BURST.
REQ-011 BURST: SHALL corrupt every header and decrement remaining, ignoring triggers, and SHALL return to IDLE in the cycle the last header is corrupted.
REQ-012 SHALL sample cfg_burst_len only on entry to BURST; changes during a burst SHALL have no effect on that burst.
REQ-013 When cfg_enable=0 in BURST, SHALL abort to IDLE in that cycle and SHALL NOT corrupt that header.
REQ-014 SHALL increment stat_inj_count on every corrupted header, and both counters SHALL saturate at 32'hFFFFFFFF.
REQ-015 When stat_clear=1, counters SHALL become 0 in that cycle and the clear SHALL win over a simultaneous increment; the FSM and LFSR SHALL be unaffected.
REQ-016 When cfg_threshold=0 and cfg_force=0, SHALL never corrupt; out_* SHALL equal in_* delayed by 1 cycle.

Reset
REQ-017 On rst_n=0, the module SHALL immediately set:
- out_data=0, out_hdr=0, out_err=0, busy=0;
- both counters=0, FSM=IDLE, remaining=0, LFSR=LFSR_SEED.
REQ-018 When reset is asserted mid-burst, the burst SHALL be discarded; after release the FSM SHALL start in IDLE.
REQ-019 Reset release SHALL take effect on the first rising clk edge after rst_n=1.

Configuration
REQ-020 Macro HDR_ERR_INJECT_DATA_FLIP_EN:
- Defined: on each corrupted header, SHALL also invert out_data bit index LFSR[5:0] mod DATA_WIDTH.
- Undefined: out_data SHALL always be in_data delayed by 1 cycle, and no data-flip logic SHALL be present.

Verification
REQ-021 cfg_enable=1, threshold=0, no force, 1000 cycles of 10/01 headers -> out_hdr equals in_hdr delayed 1 cycle, out_err=0, counters=0.
REQ-022 threshold=0, burst_len=4, single cfg_force pulse -> exactly 4 consecutive headers corrupted (10->11), busy high for 3 cycles, inj_count=4, evt_count=1.
REQ-023 burst_len=8, force, then cfg_enable=0 after 3 corrupted headers -> no further corruption, busy=0, inj_count=3.
REQ-024 rst_n pulsed low mid-burst -> outputs and counters are 0 immediately; after release, out_hdr passes in_hdr uncorrupted.
REQ-025 LFSR_SEED=32'hACE1, threshold=32'h13760000 (~0.076), 10000 cycles -> inj_count matches a cycle-exact reference model; stat_clear asserted together with an injection leaves counters at 0.
REQ-026 With the macro defined, force an event -> exactly one out_data bit differs at the LFSR-selected index; without the macro, out_data is unmodified.
